// File: rtl/reorder_commit_queue.sv
// In-order retirement queue: holds superseded PRNs per renamed instruction and frees them at commit.
// Optional RCQ_RETIRE_COUNT_EN adds a retired_count output and a commit trace message.
module reorder_commit_queue #(
    parameter  int DEPTH        = 16,
    parameter  int PRN_BITS     = 6,
    parameter  int ARN_BITS     = 6,
    parameter  int MAX_OPERANDS = 3,
    localparam int TAG_BITS     = $clog2(DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   alloc_valid,
    output logic                                   alloc_ready,
    input  logic [MAX_OPERANDS-1:0]                alloc_prn_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  alloc_prn,
    input  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]  alloc_arn,
    output logic [TAG_BITS-1:0]                    alloc_tag,
    input  logic                                   complete_valid,
    input  logic [TAG_BITS-1:0]                    complete_tag,
    output logic [MAX_OPERANDS-1:0]                free_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  free_prns,
    output logic                                   commit_valid,
    output logic [TAG_BITS:0]                      count,
    output logic                                   complete_err
`ifdef RCQ_RETIRE_COUNT_EN
    ,
    output logic [31:0]                            retired_count
`endif
);

    localparam logic [TAG_BITS:0] FULL_COUNT = (TAG_BITS+1)'(DEPTH);

    logic [TAG_BITS-1:0] head;
    logic [TAG_BITS-1:0] tail;
    logic [DEPTH-1:0]    occ;
    logic [DEPTH-1:0]    done;

    logic [MAX_OPERANDS-1:0]               slot_v   [DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] slot_prn [DEPTH];
    logic [MAX_OPERANDS-1:0][ARN_BITS-1:0] slot_arn [DEPTH];

    logic alloc_fire;
    logic commit_fire;
    logic complete_ok;

    // Ready depends on registered count only, so a same-cycle commit never opens room.
    assign alloc_ready = (count != FULL_COUNT);
    assign alloc_tag   = tail;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = occ[head] && done[head];
    assign complete_ok = occ[complete_tag] && !done[complete_tag];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            occ          <= '0;
            done         <= '0;
            free_valid   <= '0;
            free_prns    <= '0;
            commit_valid <= 1'b0;
            complete_err <= 1'b0;
        end else begin
            if (alloc_fire) begin
                occ[tail]  <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= tail + 1'b1;
            end
            // Tail can only alias an occupied entry when full, so alloc and complete never collide.
            if (complete_valid) begin
                if (complete_ok)
                    done[complete_tag] <= 1'b1;
                else
                    complete_err <= 1'b1;
            end
            if (commit_fire) begin
                occ[head]    <= 1'b0;
                done[head]   <= 1'b0;
                head         <= head + 1'b1;
                free_valid   <= slot_v[head];
                free_prns    <= slot_prn[head];
                commit_valid <= 1'b1;
            end else begin
                free_valid   <= '0;
                commit_valid <= 1'b0;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            slot_v[tail]   <= alloc_prn_valid;
            slot_prn[tail] <= alloc_prn;
            slot_arn[tail] <= alloc_arn;
        end
    end

`ifdef RCQ_RETIRE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_count <= '0;
        end else if (commit_fire) begin
            retired_count <= retired_count + 1'b1;
            $display("RCQ commit tag %0d arn %0h", head, slot_arn[head]);
        end
    end
`endif

endmodule

// File: tb/tb_reorder_commit_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_reorder_commit_queue;

    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             alloc_valid = 1'b0;
    logic             alloc_ready;
    logic [2:0]       alloc_prn_valid = '0;
    logic [2:0][5:0]  alloc_prn = '0;
    logic [2:0][5:0]  alloc_arn = '0;
    logic [3:0]       alloc_tag;
    logic             complete_valid = 1'b0;
    logic [3:0]       complete_tag = '0;
    logic [2:0]       free_valid;
    logic [2:0][5:0]  free_prns;
    logic             commit_valid;
    logic [4:0]       count;
    logic             complete_err;

    reorder_commit_queue dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_prn_valid(alloc_prn_valid), .alloc_prn(alloc_prn), .alloc_arn(alloc_arn),
        .alloc_tag(alloc_tag),
        .complete_valid(complete_valid), .complete_tag(complete_tag),
        .free_valid(free_valid), .free_prns(free_prns),
        .commit_valid(commit_valid), .count(count), .complete_err(complete_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             done;
        bit [2:0]       v;
        bit [2:0][5:0]  prn;
    } ent_t;

    ent_t            q[$];
    int              m_head, m_tail;
    bit              e_cv, e_err;
    bit [2:0]        e_fv;
    bit [2:0][5:0]   e_fp;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_head = 0; m_tail = 0;
        e_cv = 0; e_err = 0; e_fv = '0; e_fp = '0;
    endtask

    task automatic check_all();
        check("count", 64'(count), 64'(q.size()));
        check("alloc_ready", 64'(alloc_ready), 64'(q.size() < DEPTH));
        check("alloc_tag", 64'(alloc_tag), 64'(m_tail));
        check("commit_valid", 64'(commit_valid), 64'(e_cv));
        check("free_valid", 64'(free_valid), 64'(e_fv));
        check("free_prns", 64'(free_prns), 64'(e_fp));
        check("complete_err", 64'(complete_err), 64'(e_err));
    endtask

    // One clock: drive inputs, advance the model by the queue rules, then compare after the edge.
    task automatic step(input bit av, input bit [2:0] pv, input bit [2:0][5:0] prns,
                        input bit cv, input int ct);
        bit do_commit, accept;
        int idx;
        ent_t e;
        alloc_valid = av; alloc_prn_valid = pv; alloc_prn = prns;
        alloc_arn = 18'($urandom);
        complete_valid = cv; complete_tag = 4'(ct);
        do_commit = (q.size() > 0) && q[0].done;
        accept = av && (q.size() < DEPTH);
        if (cv) begin
            idx = (ct - m_head + DEPTH) % DEPTH;
            if (idx < q.size() && !q[idx].done) q[idx].done = 1;
            else e_err = 1;
        end
        if (do_commit) begin
            e_cv = 1; e_fv = q[0].v; e_fp = q[0].prn;
            void'(q.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end else begin
            e_cv = 0; e_fv = '0;
        end
        if (accept) begin
            e.done = 0; e.v = pv; e.prn = prns;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_valid = 0; complete_valid = 0;
        #2;
        model_reset();
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        model_reset();
        #12;
        do_reset();

        // Single entry: complete in cycle N, freed PRNs visible in cycle N+2.
        step(1, 3'b011, {6'd0, 6'd9, 6'd7}, 0, 0);
        step(0, '0, '0, 1, 0);
        check("no_early_commit", 64'(commit_valid), 64'd0);
        step(0, '0, '0, 0, 0);
        check("single_free_valid", 64'(free_valid), 64'h3);
        check("single_free_prns", 64'(free_prns[1:0]), 64'h247);
        check("single_commit", 64'(commit_valid), 64'd1);
        idle(2);

        // Out-of-order completion, in-order retirement.
        step(1, 3'b001, {6'd0, 6'd0, 6'd11}, 0, 0);
        step(1, 3'b010, {6'd0, 6'd12, 6'd0}, 0, 0);
        step(1, 3'b100, {6'd13, 6'd0, 6'd0}, 0, 0);
        step(0, '0, '0, 1, 3);
        step(0, '0, '0, 1, 2);
        check("ooo_hold", 64'(commit_valid), 64'd0);
        step(0, '0, '0, 1, 1);
        idle(4);

        // Fill to DEPTH, then commit the head while alloc is held.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 3'b111, 18'(i * 3 + 1), 0, 0);
        check("full_count", 64'(count), 64'd16);
        check("full_ready", 64'(alloc_ready), 64'd0);
        step(1, 3'b001, 18'd5, 1, 0);
        step(1, 3'b001, 18'd5, 0, 0);
        step(1, 3'b001, 18'd6, 0, 0);
        check("wrap_tag", 64'(alloc_tag), 64'd1);
        idle(2);

        // Error cases: unallocated tag, then double completion.
        do_reset();
        step(0, '0, '0, 1, 5);
        check("err_unalloc", 64'(complete_err), 64'd1);
        step(1, 3'b001, 18'd2, 0, 0);
        step(0, '0, '0, 1, 0);
        step(0, '0, '0, 1, 0);
        idle(3);

        // Alloc and commit together at count 3.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 3'b001, 18'(i + 20), 0, 0);
        step(0, '0, '0, 1, 0);
        step(1, 3'b001, 18'd30, 0, 0);
        check("alloc_commit_count", 64'(count), 64'd3);

        // Reset mid-stream with 5 entries.
        step(1, 3'b001, 18'd31, 0, 0);
        step(1, 3'b001, 18'd32, 0, 0);
        check("pre_reset_count", 64'(count), 64'd5);
        do_reset();
        check("post_reset_tag", 64'(alloc_tag), 64'd0);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            bit av, cv;
            int ct;
            av = ($urandom % 10) < 6;
            cv = ($urandom % 10) < 6;
            if (q.size() > 0 && ($urandom % 8) != 0)
                ct = (m_head + int'($urandom_range(0, q.size() - 1))) % DEPTH;
            else
                ct = int'($urandom_range(0, DEPTH - 1));
            step(av, 3'($urandom), 18'($urandom), cv, ct);
            if (($urandom % 500) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
